// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the hazard controller and the IF/ID/EX/MEM pipeline stages.
// The controller takes the slave side; the pipeline (or a bench) takes the master side.
interface pipe_hazard_ctrl_if #(
    parameter int GPR_ADR = 5,
    parameter int CNT_W   = 32
);
    logic               id_valid;
    logic [GPR_ADR-1:0] id_rs;
    logic [GPR_ADR-1:0] id_rt;
    logic               id_uses_rt;
    logic               ex_mem_read;
    logic [GPR_ADR-1:0] ex_dst;
    logic               md_start;
    logic               md_done;
    logic               mem_req;
    logic               mem_ack;
    logic               branch_taken;

    logic               pc_ena_n;
    logic               id_ena_n;
    logic               ex_hold;
    logic               ex_bubble;
    logic               id_flush;
    logic               md_err;
    logic [CNT_W-1:0]   stall_cnt;
    logic [1:0]         busy_state;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rt, ex_mem_read, ex_dst,
               md_start, md_done, mem_req, mem_ack, branch_taken,
        input  pc_ena_n, id_ena_n, ex_hold, ex_bubble, id_flush, md_err,
               stall_cnt, busy_state
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rt, ex_mem_read, ex_dst,
               md_start, md_done, mem_req, mem_ack, branch_taken,
        output pc_ena_n, id_ena_n, ex_hold, ex_bubble, id_flush, md_err,
               stall_cnt, busy_state
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// IF/ID/EX stall, bubble and flush sequencing for load-use, mul/div and memory-wait hazards.
// Optional stalled-cycle counter is built only when PIPE_STALL_CNT_EN is defined.
//
// state      | meaning
// IDLE       | no stall pending; hazards are evaluated combinationally this cycle
// LOAD_STALL | single bubble cycle after a load-use stall
// MD_BUSY    | waiting on the mul/div unit, bounded by MD_MAX_CYC
// MEM_WAIT   | waiting for the data memory acknowledge
module pipe_hazard_ctrl #(
    parameter int GPR_ADR    = 5,
    parameter int OPC_BIT    = 6,
    parameter int MD_MAX_CYC = 40,
    parameter int CNT_W      = 32
) (
    input logic            clk,
    input logic            rst,
    pipe_hazard_ctrl_if.slave bus
);
    localparam int MD_W = $clog2(MD_MAX_CYC + 1);

    if (OPC_BIT < 1 || GPR_ADR < 1 || MD_MAX_CYC < 1 || CNT_W < 1) begin : g_param_chk
        $error("pipe_hazard_ctrl: parameters must all be positive");
    end

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LOAD_STALL = 2'd1,
        MD_BUSY    = 2'd2,
        MEM_WAIT   = 2'd3
    } state_t;

    state_t          state;
    logic [MD_W-1:0] md_cnt;
    logic            md_err_q;

    logic lu;
    logic mw;
    logic md;
    logic md_tmo;
    logic hold_pc;
    logic hold_ex;
    logic bubble;

    assign lu = bus.id_valid & bus.ex_mem_read & (bus.ex_dst != '0) &
                ((bus.ex_dst == bus.id_rs) | (bus.id_uses_rt & (bus.ex_dst == bus.id_rt)));
    assign mw     = bus.mem_req & ~bus.mem_ack;
    assign md     = bus.md_start & ~bus.md_done;
    assign md_tmo = (md_cnt == MD_W'(MD_MAX_CYC));

    // A taken branch squashes the ID instruction, so its load-use stall is dropped.
    always_comb begin
        hold_pc = 1'b0;
        hold_ex = 1'b0;
        bubble  = 1'b0;
        case (state)
            IDLE: begin
                if (mw || md) begin
                    hold_pc = 1'b1;
                    hold_ex = 1'b1;
                end else if (lu && !bus.branch_taken) begin
                    hold_pc = 1'b1;
                    bubble  = 1'b1;
                end
            end
            MD_BUSY: begin
                if (!bus.md_done && !md_tmo) begin
                    hold_pc = 1'b1;
                    hold_ex = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (!bus.mem_ack) begin
                    hold_pc = 1'b1;
                    hold_ex = 1'b1;
                end
            end
            default: ;
        endcase
        if (rst) begin
            hold_pc = 1'b0;
            hold_ex = 1'b0;
            bubble  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            md_cnt   <= '0;
            md_err_q <= 1'b0;
        end else begin
            md_err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (mw) begin
                        state <= MEM_WAIT;
                    end else if (md) begin
                        state  <= MD_BUSY;
                        md_cnt <= MD_W'(1);
                    end else if (lu && !bus.branch_taken) begin
                        state <= LOAD_STALL;
                    end
                end
                LOAD_STALL: state <= IDLE;
                MD_BUSY: begin
                    if (bus.md_done) begin
                        state  <= IDLE;
                        md_cnt <= '0;
                    end else if (md_tmo) begin
                        state    <= IDLE;
                        md_cnt   <= '0;
                        md_err_q <= 1'b1;
                    end else begin
                        md_cnt <= md_cnt + 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (bus.mem_ack) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.pc_ena_n   = hold_pc;
    assign bus.id_ena_n   = hold_pc;
    assign bus.ex_hold    = hold_ex;
    assign bus.ex_bubble  = bubble;
    assign bus.id_flush   = bus.branch_taken & ~hold_ex & ~rst;
    assign bus.md_err     = md_err_q;
    assign bus.busy_state = state;

`ifdef PIPE_STALL_CNT_EN
    logic [CNT_W-1:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (hold_pc && (stall_q != '1)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign bus.stall_cnt = stall_q;
`else
    assign bus.stall_cnt = '0;
`endif
endmodule
